stack_ram_sequencer: RTL and testbench
======================================

// Module: stack_ram_sequencer
// PURPOSE
//  Turns stack commands (push/pop/clear) from the calculator controller into accesses on one
//  single-port synchronous RAM. Keeps the stack pointer, caches the top-of-stack in a register
//  and reports empty/full. One instance serves the data stack (dt) and one the operator stack (op).
// PARAMETERS
//  DATA_W      16  width of one stack entry (operand or operator code)
//  DEPTH_LOG2   4  log2 of stack depth; DEPTH = 2**DEPTH_LOG2 entries
// PORTS
//  Clock      in   1             system clock, rising edge
//  Reset      in   1             asynchronous, active-low reset
//  cmd        in   2             00 NONE, 01 PUSH, 10 POP, 11 CLEAR
//  cmd_data   in   DATA_W        value to push (sampled with PUSH)
//  ready      out  1             1 = cmd sampled this cycle; 0 = cmd ignored
//  top_data   out  DATA_W        current top-of-stack (0 when empty)
//  empty      out  1             count == 0
//  full       out  1             count == DEPTH
//  count      out  DEPTH_LOG2+1  number of entries held
//  err        out  1             sticky misuse flag (STACK_ERR_EN only, else tied 0)
//  ram_addr   out  DEPTH_LOG2    RAM address (combinational)
//  ram_we     out  1             RAM write enable (combinational)
//  ram_wdata  out  DATA_W        RAM write data (= cmd_data)
//  ram_rdata  in   DATA_W        RAM read data, valid the cycle after ram_addr presented
// BEHAVIOUR
//  - Reset: state IDLE, count=0, top_data=0, err=0, ready=1, ram_we=0, ram_addr=0.
//  - Storage: entries at RAM[0..count-1]; top_data register always mirrors RAM[count-1].
//  - FSM IDLE (ready=1):
//    PUSH & !full : ram_we=1, ram_addr=count, top_data<=cmd_data, count++; stay IDLE (1 cycle).
//    POP & count>1: ram_addr=count-2, count--; go REFILL.
//    POP & count==1: count<=0, top_data<=0; stay IDLE, no RAM access.
//    CLEAR        : count<=0, top_data<=0, no RAM access; stay IDLE.
//    PUSH & full / POP & empty: no state change, no RAM access (see CONFIGURATION for err).
//  - FSM REFILL (ready=0): top_data<=ram_rdata; go IDLE. Any cmd this cycle is ignored;
//    requester holds cmd until ready=1. POP latency to valid top_data = 2 cycles.
//  - ram_we is 1 only for accepted PUSH; ram_addr=0 whenever no access is issued.
//  - empty/full/count are registered, update the cycle after the accepted command.
//  - count never wraps: saturates by rule above at 0 and DEPTH.
//  - Reset asserted during REFILL: read abandoned, all outputs to reset values immediately.
// CONFIGURATION
//  STACK_ERR_EN defined: err set (sticky) on PUSH when full or POP when empty in IDLE;
//    cleared only by accepted CLEAR or Reset. Command itself still ignored.
//  STACK_ERR_EN undefined: err constant 0, no err register synthesized.
// TESTING
//  1 PUSH 0x11,0x22,0x33 back-to-back -> ready=1 each cycle, RAM[0..2]=11,22,33, count=3, top=0x33.
//  2 From 1, POP -> ram_addr=1, ready=0 one cycle, then top=0x22, count=2; POP,POP -> empty=1, top=0.
//  3 Fill DEPTH=16 entries, PUSH 0xAA -> full=1, no ram_we, count=16, top unchanged; err=1 if STACK_ERR_EN.
//  4 POP on empty -> count=0, no RAM access, err=1 with STACK_ERR_EN; then CLEAR -> err=0.
//  5 PUSH issued during REFILL -> ignored, ready=0; held to next cycle -> accepted, top=new value.
//  6 Reset low in REFILL after count=5 -> count=0, top=0, ready=1, ram_we=0 without waiting for edge.

Source files
------------

// File: rtl/stack_ram_sequencer.sv
// stack_ram_sequencer
//   Converts push/pop/clear commands into accesses on one single-port synchronous
//   RAM. It keeps the stack pointer, holds a cached copy of the top-of-stack and
//   reports empty/full.
//   Optional feature: define STACK_ERR_EN to build the sticky misuse flag 'err'.
//
//   Handshake: 'ready' is high when 'cmd' is sampled in this cycle. When 'ready'
//   is low, the command is ignored. The requester holds the command until it sees
//   'ready' high. A command only counts when it is presented in the same cycle as
//   'ready' is high.
//
//   Debug: 'state_dbg' exposes the FSM state (0 = IDLE, 1 = REFILL).
module stack_ram_sequencer #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [1:0]            cmd,
    input  logic [DATA_W-1:0]     cmd_data,
    output logic                  ready,
    output logic [DATA_W-1:0]     top_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  err,
    output logic [DEPTH_LOG2-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  state_dbg
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_PUSH  = 2'b01;
    localparam logic [1:0] CMD_POP   = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t                state, state_n;
    logic [DEPTH_LOG2:0]   count_n;
    logic [DATA_W-1:0]     top_n;

    assign ram_wdata = cmd_data;
    assign state_dbg = state;

    // Next-state and RAM access decode. While Reset is asserted, no access is issued.
    always_comb begin
        state_n  = state;
        count_n  = count;
        top_n    = top_data;
        ram_we   = 1'b0;
        ram_addr = '0;
        ready    = (state == IDLE);
        case (state)
            IDLE: begin
                if (Reset) begin
                    case (cmd)
                        CMD_PUSH: begin
                            if (!full) begin
                                ram_we   = 1'b1;
                                ram_addr = DEPTH_LOG2'(count);
                                top_n    = cmd_data;
                                count_n  = count + 1'b1;
                            end
                        end
                        CMD_POP: begin
                            if (count > 1) begin
                                // The new top lives one slot below the old top.
                                ram_addr = DEPTH_LOG2'(count - 2);
                                count_n  = count - 1'b1;
                                state_n  = REFILL;
                            end else if (count == 1) begin
                                count_n = '0;
                                top_n   = '0;
                            end
                        end
                        CMD_CLEAR: begin
                            count_n = '0;
                            top_n   = '0;
                        end
                        CMD_NONE: ;
                        default: ;
                    endcase
                end
            end
            REFILL: begin
                // Read data for the address issued last cycle arrives now.
                top_n   = ram_rdata;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, pointer, cached top and the registered empty/full flags.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            count    <= '0;
            top_data <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            top_data <= top_n;
            empty    <= (count_n == '0);
            full     <= (count_n == DEPTH_C);
        end
    end

`ifdef STACK_ERR_EN
    // Sticky misuse flag. It is set by PUSH while full or POP while empty, and it is cleared by CLEAR.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            err <= 1'b0;
        end else if (state == IDLE) begin
            if (cmd == CMD_CLEAR)
                err <= 1'b0;
            else if ((cmd == CMD_PUSH && full) || (cmd == CMD_POP && empty))
                err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_ram_sequencer.sv
// Testbench for stack_ram_sequencer. It uses a behavioural single-port RAM,
// table vectors, and a stack scoreboard.
module tb_stack_ram_sequencer;

  localparam int DW = 16;
  localparam int DL = 4;
  localparam int DEPTH = 16;

`ifdef STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_PUSH  = 2'b01;
  localparam logic [1:0] C_POP   = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  logic          clk;
  logic          rst_n;
  logic [1:0]    cmd;
  logic [DW-1:0] cmd_data;
  logic          ready;
  logic [DW-1:0] top_data;
  logic          empty;
  logic          full;
  logic [DL:0]   count;
  logic          err;
  logic [DL-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          state_dbg;

  logic [DW-1:0] mem [DEPTH];

  int n_vec = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q [$];

  // sampled DUT values: combinational before the edge, registered after it
  logic          s_ready, s_we;
  logic [DL-1:0] s_addr;
  logic [DW-1:0] s_wdata;

  stack_ram_sequencer #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (
    .Clock(clk), .Reset(rst_n), .cmd(cmd), .cmd_data(cmd_data),
    .ready(ready), .top_data(top_data), .empty(empty), .full(full),
    .count(count), .err(err), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous single-port RAM model, read data one cycle after address
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive one command at the falling edge, sample the combinational outputs, and step past the rising edge
  task automatic apply(input logic [1:0] c, input logic [DW-1:0] d);
    @(negedge clk);
    cmd = c;
    cmd_data = d;
    #1;
    s_ready = ready;
    s_we = ram_we;
    s_addr = ram_addr;
    s_wdata = ram_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [DW-1:0] v);
    int sz;
    sz = exp_q.size();
    apply(C_PUSH, v);
    chk("push_ready", 32'(s_ready), 32'd1);
    chk("push_we", 32'(s_we), 32'd1);
    chk("push_addr", 32'(s_addr), 32'(sz));
    chk("push_wdata", 32'(s_wdata), 32'(v));
    exp_q.push_back(v);
    chk("push_top", 32'(top_data), 32'(exp_q[$]));
    chk("push_count", 32'(count), 32'(exp_q.size()));
  endtask

  task automatic sb_pop();
    int pc;
    logic [DW-1:0] e_top;
    pc = exp_q.size();
    apply(C_POP, '0);
    chk("pop_ready", 32'(s_ready), 32'd1);
    chk("pop_we", 32'(s_we), 32'd0);
    chk("pop_addr", 32'(s_addr), (pc > 1) ? 32'(pc - 2) : 32'd0);
    if (pc > 0) exp_q.pop_back();
    apply(C_NONE, '0);
    chk("pop_refill_ready", 32'(s_ready), (pc > 1) ? 32'd0 : 32'd1);
    e_top = (exp_q.size() > 0) ? exp_q[$] : '0;
    chk("pop_top", 32'(top_data), 32'(e_top));
    chk("pop_count", 32'(count), 32'(exp_q.size()));
    chk("pop_empty", 32'(empty), (exp_q.size() == 0) ? 32'd1 : 32'd0);
  endtask

  typedef struct {
    logic [1:0]    c;
    logic [DW-1:0] d;
    logic          e_ready;
    logic          e_we;
    logic [DL-1:0] e_addr;
    logic [DW-1:0] e_top;
    logic [DL:0]   e_count;
    logic          e_empty;
    logic          e_err_if_en;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] held;

    vt[0] = '{C_PUSH,  16'h0011, 1, 1, 4'd0, 16'h0011, 5'd1, 0, 0};
    vt[1] = '{C_PUSH,  16'h0022, 1, 1, 4'd1, 16'h0022, 5'd2, 0, 0};
    vt[2] = '{C_PUSH,  16'h0033, 1, 1, 4'd2, 16'h0033, 5'd3, 0, 0};
    vt[3] = '{C_POP,   16'h0000, 1, 0, 4'd1, 16'h0033, 5'd2, 0, 0};
    vt[4] = '{C_NONE,  16'h0000, 0, 0, 4'd0, 16'h0022, 5'd2, 0, 0};
    vt[5] = '{C_POP,   16'h0000, 1, 0, 4'd0, 16'h0022, 5'd1, 0, 0};
    vt[6] = '{C_NONE,  16'h0000, 0, 0, 4'd0, 16'h0011, 5'd1, 0, 0};
    vt[7] = '{C_POP,   16'h0000, 1, 0, 4'd0, 16'h0000, 5'd0, 1, 0};
    vt[8] = '{C_POP,   16'h0000, 1, 0, 4'd0, 16'h0000, 5'd0, 1, 1};
    vt[9] = '{C_CLEAR, 16'h0000, 1, 0, 4'd0, 16'h0000, 5'd0, 1, 0};

    cmd = C_NONE;
    cmd_data = '0;
    rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #12;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_top", 32'(top_data), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table: push three, pop back to empty, misuse pop, clear
    for (int i = 0; i < 10; i++) begin
      apply(vt[i].c, vt[i].d);
      chk($sformatf("v%0d_ready", i), 32'(s_ready), 32'(vt[i].e_ready));
      chk($sformatf("v%0d_we", i), 32'(s_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d_addr", i), 32'(s_addr), 32'(vt[i].e_addr));
      chk($sformatf("v%0d_top", i), 32'(top_data), 32'(vt[i].e_top));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].e_count));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vt[i].e_empty));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(ERR_EN & vt[i].e_err_if_en));
    end
    chk("ram0", 32'(mem[0]), 32'h11);
    chk("ram1", 32'(mem[1]), 32'h22);
    chk("ram2", 32'(mem[2]), 32'h33);

    // fill to DEPTH, then push while full
    for (int i = 0; i < DEPTH; i++) begin
      v = DW'($urandom_range(1, 16'hFFFF));
      sb_push(v);
    end
    chk("full_flag", 32'(full), 32'd1);
    apply(C_PUSH, 16'h00AA);
    chk("full_push_ready", 32'(s_ready), 32'd1);
    chk("full_push_we", 32'(s_we), 32'd0);
    chk("full_push_count", 32'(count), 32'd16);
    chk("full_push_top", 32'(top_data), 32'(exp_q[$]));
    chk("full_push_err", 32'(err), 32'(ERR_EN));

    // drain with scoreboard checks on every refilled top
    for (int i = 0; i < DEPTH; i++) sb_pop();
    chk("drained_err_sticky", 32'(err), 32'(ERR_EN));
    apply(C_CLEAR, '0);
    chk("clear_err", 32'(err), 32'd0);
    chk("clear_count", 32'(count), 32'd0);

    // PUSH presented during REFILL is ignored, then accepted when held
    sb_push(16'h0101);
    sb_push(16'h0202);
    apply(C_POP, '0);
    exp_q.pop_back();
    held = 16'h0BEE;
    apply(C_PUSH, held);
    chk("refill_push_ready", 32'(s_ready), 32'd0);
    chk("refill_push_we", 32'(s_we), 32'd0);
    chk("refill_push_top", 32'(top_data), 32'h0101);
    chk("refill_push_count", 32'(count), 32'd1);
    sb_push(held);

    // Reset asserted during REFILL takes effect without waiting for an edge
    sb_push(16'h0303);
    sb_push(16'h0404);
    sb_push(16'h0505);
    chk("five_count", 32'(count), 32'd5);
    apply(C_POP, '0);
    @(negedge clk);
    chk("in_refill", 32'(ready), 32'd0);
    cmd = C_PUSH;
    cmd_data = 16'h0777;
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_top", 32'(top_data), 32'd0);
    chk("async_ready", 32'(ready), 32'd1);
    chk("async_we", 32'(ram_we), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    exp_q.delete();
    @(negedge clk);
    cmd = C_NONE;
    rst_n = 1'b1;
    sb_push(16'h0909);
    sb_pop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
